keypad_scan_4x4: RTL and testbench

Scanner/decoder for a 4x4 passive matrix keypad, the input-side counterpart to the multiplexed 7-segment display driver. Drives one active-low row at a time, samples the column lines, debounces across full scans and emits a 4-bit key code with a single-cycle strobe on each accepted press. Sits beside the display driver in the stopwatch/clock tops and feeds start/stop/clear and digit entry into the control logic, all in the `clk_50M` domain.

---
 rtl/keypad_scan_4x4_pkg.sv | 18 +
 rtl/keypad_scan_4x4_if.sv | 27 ++
 rtl/keypad_scan_4x4_debounce.sv | 93 +++++++++
 rtl/keypad_scan_4x4.sv | 95 +++++++++
 tb/tb_keypad_scan_4x4.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/keypad_scan_4x4_pkg.sv
// rtl/keypad_scan_4x4_pkg.sv - shared types and constants for the 4x4 keypad scanner
package keypad_pkg;

    localparam int CODE_W = 4;
    localparam logic [3:0] ROW_RESET = 4'b1110;

    typedef enum logic {
        RELEASED = 1'b0,
        PRESSED  = 1'b1
    } key_state_e;

    // Result of one full scan: hit flag plus the lowest pressed key code
    typedef struct packed {
        logic              hit;
        logic [CODE_W-1:0] code;
    } scan_result_t;

endpackage

// File: rtl/keypad_scan_4x4_if.sv
// rtl/keypad_scan_4x4_if.sv - keypad matrix lines and decoded key outputs
interface keypad_if;
    import keypad_pkg::*;

    logic [3:0]        col;
    logic [3:0]        row;
    logic [CODE_W-1:0] key_code;
    logic              key_valid;
    logic              key_down;

    modport master (
        input  col,
        output row,
        output key_code,
        output key_valid,
        output key_down
    );

    modport slave (
        output col,
        input  row,
        input  key_code,
        input  key_valid,
        input  key_down
    );

endinterface

// File: rtl/keypad_scan_4x4_debounce.sv
// rtl/keypad_scan_4x4_debounce.sv - scan-level debounce and press/release FSM
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 5
) (
    input  logic              clk_50M,
    input  logic              rst,
    input  logic              scan_end_i,
    input  scan_result_t      result_i,
    output logic [CODE_W-1:0] key_code_o,
    output logic              key_valid_o,
    output logic              key_down_o
);

    localparam logic [3:0] DB_CNT = 4'(DEBOUNCE_SCANS);

    key_state_e        state_q, state_d;
    scan_result_t      cand_q, cand_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [CODE_W-1:0] key_code_q, key_code_d;
    logic              key_valid_q, key_valid_d;
    logic              key_down_q, key_down_d;
    logic              stable;

    // State and output registers
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            state_q     <= RELEASED;
            cand_q      <= '0;
            cnt_q       <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
        end
    end

    // Candidate tracking and FSM; stability uses the freshly updated count
    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_down_d  = key_down_q;
        stable      = 1'b0;

        if (scan_end_i) begin
            if (result_i == cand_q) begin
                cnt_d = (cnt_q >= DB_CNT) ? DB_CNT : cnt_q + 4'd1;
            end else begin
                cand_d = result_i;
                cnt_d  = 4'd1;
            end
            stable = (cnt_d == DB_CNT);

            case (state_q)
                RELEASED: begin
                    if (stable && cand_d.hit) begin
                        key_code_d  = cand_d.code;
                        key_valid_d = 1'b1;
                        key_down_d  = 1'b1;
                        state_d     = PRESSED;
                    end
                end
                PRESSED: begin
                    if (stable) begin
                        if (!cand_d.hit) begin
                            key_down_d = 1'b0;
                            state_d    = RELEASED;
                        end else if (cand_d.code != key_code_q) begin
                            key_code_d  = cand_d.code;
                            key_valid_d = 1'b1;
                        end
                    end
                end
                default: state_d = RELEASED;
            endcase
        end
    end

    assign key_code_o  = key_code_q;
    assign key_valid_o = key_valid_q;
    assign key_down_o  = key_down_q;

endmodule

// File: rtl/keypad_scan_4x4.sv
// rtl/keypad_scan_4x4.sv - 4x4 matrix keypad row scanner and key decoder
module keypad_scan_4x4
    import keypad_pkg::*;
#(
    parameter int SCAN_CNTMAX    = 49999,
    parameter int DEBOUNCE_SCANS = 5
) (
    input  logic clk_50M,
    input  logic rst,
    keypad_if.master kp
);

    localparam int CNT_W = (SCAN_CNTMAX < 1) ? 1 : $clog2(SCAN_CNTMAX + 1);

    logic [3:0]        col_meta_q, col_sync_q;
    logic [CNT_W-1:0]  slot_cnt_q, slot_cnt_d;
    logic [1:0]        row_idx_q, row_idx_d;
    logic              acc_hit_q, acc_hit_d;
    logic [CODE_W-1:0] acc_code_q, acc_code_d;

    logic              slot_end;
    logic              scan_end;
    logic              row_hit;
    logic [1:0]        row_col;
    scan_result_t      scan_res;

    // Column synchronizer, slot counter, row index and scan accumulator
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            col_meta_q <= 4'hF;
            col_sync_q <= 4'hF;
            slot_cnt_q <= '0;
            row_idx_q  <= '0;
            acc_hit_q  <= 1'b0;
            acc_code_q <= '0;
        end else begin
            col_meta_q <= kp.col;
            col_sync_q <= col_meta_q;
            slot_cnt_q <= slot_cnt_d;
            row_idx_q  <= row_idx_d;
            acc_hit_q  <= acc_hit_d;
            acc_code_q <= acc_code_d;
        end
    end

    // Lowest pressed column of the current row; scanning downward lets the lowest index win
    always_comb begin
        row_hit = 1'b0;
        row_col = 2'd0;
        for (int c = 3; c >= 0; c--) begin
            if (!col_sync_q[c]) begin
                row_hit = 1'b1;
                row_col = 2'(c);
            end
        end
    end

    // Merge this row into the scan; earlier rows keep priority
    always_comb begin
        slot_end      = (slot_cnt_q == CNT_W'(SCAN_CNTMAX));
        scan_end      = slot_end && (row_idx_q == 2'd3);
        scan_res.hit  = acc_hit_q | row_hit;
        scan_res.code = acc_hit_q ? acc_code_q
                      : (row_hit ? {row_idx_q, row_col} : '0);

        slot_cnt_d = slot_end ? '0 : slot_cnt_q + CNT_W'(1);
        row_idx_d  = slot_end ? row_idx_q + 2'd1 : row_idx_q;
        acc_hit_d  = acc_hit_q;
        acc_code_d = acc_code_q;
        if (slot_end) begin
            if (scan_end) begin
                acc_hit_d  = 1'b0;
                acc_code_d = '0;
            end else begin
                acc_hit_d  = scan_res.hit;
                acc_code_d = scan_res.code;
            end
        end
    end

    assign kp.row = ~(4'b0001 << row_idx_q);

    keypad_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .clk_50M     (clk_50M),
        .rst         (rst),
        .scan_end_i  (scan_end),
        .result_i    (scan_res),
        .key_code_o  (kp.key_code),
        .key_valid_o (kp.key_valid),
        .key_down_o  (kp.key_down)
    );

endmodule

// File: tb/tb_keypad_scan_4x4.sv
// tb/tb_keypad_scan_4x4.sv - directed self-checking bench for keypad_scan_4x4
module tb_keypad_scan_4x4;

    logic        clk_50M = 1'b0;
    logic        rst     = 1'b1;
    logic [15:0] keys    = 16'h0000;

    int checks   = 0;
    int failures = 0;

    int       valid_total = 0;
    int       rise_total  = 0;
    int       fall_total  = 0;
    int       consec_total = 0;
    logic     prev_valid  = 1'b0;
    logic     prev_down   = 1'b0;
    logic [3:0] last_code = 4'h0;

    keypad_if kp ();

    keypad_scan_4x4 #(
        .SCAN_CNTMAX(9),
        .DEBOUNCE_SCANS(3)
    ) dut (
        .clk_50M (clk_50M),
        .rst     (rst),
        .kp      (kp)
    );

    always #5 clk_50M = ~clk_50M;

    function automatic logic [3:0] col_model(input logic [15:0] k, input logic [3:0] r);
        logic [3:0] c;
        c = 4'hF;
        for (int i = 0; i < 16; i++)
            if (k[i] && r[i / 4] == 1'b0) c[i % 4] = 1'b0;
        return c;
    endfunction

    assign kp.col = col_model(keys, kp.row);

    always @(posedge clk_50M) begin
        #2;
        if (kp.key_valid === 1'b1) begin
            valid_total <= valid_total + 1;
            last_code   <= kp.key_code;
            if (prev_valid) consec_total <= consec_total + 1;
        end
        if (kp.key_down === 1'b1 && !prev_down) rise_total <= rise_total + 1;
        if (kp.key_down !== 1'b1 && prev_down)  fall_total <= fall_total + 1;
        prev_valid <= (kp.key_valid === 1'b1);
        prev_down  <= (kp.key_down === 1'b1);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk_50M);
    endtask

    task automatic do_reset();
        @(negedge clk_50M);
        rst = 1'b1;
        @(negedge clk_50M);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] exp_rows [5];
        int base_v, base_r;
        exp_rows = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        keys = 16'h0;
        @(negedge clk_50M);
        rst = 1'b1;
        @(negedge clk_50M);
        checks++; if (kp.row !== 4'b1110) begin failures++; $display("FAIL reset_row got=%b exp=1110", kp.row); end
        checks++; if (kp.key_code !== 4'h0) begin failures++; $display("FAIL reset_code got=%0h exp=0", kp.key_code); end
        checks++; if (kp.key_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", kp.key_valid); end
        checks++; if (kp.key_down !== 1'b0) begin failures++; $display("FAIL reset_down got=%b exp=0", kp.key_down); end
        rst = 1'b0;
        step(5);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (kp.row !== exp_rows[i]) begin
                failures++; $display("FAIL row_seq%0d got=%b exp=%b", i, kp.row, exp_rows[i]);
            end
            step(10);
        end
        base_v = valid_total; base_r = rise_total;
        step(800);
        checks++; if (valid_total - base_v != 0) begin failures++; $display("FAIL idle_valid got=%0d exp=0", valid_total - base_v); end
        checks++; if (rise_total - base_r != 0) begin failures++; $display("FAIL idle_down got=%0d exp=0", rise_total - base_r); end
        checks++; if (kp.key_code !== 4'h0) begin failures++; $display("FAIL idle_code got=%0h exp=0", kp.key_code); end
    endtask

    task automatic test_single_key();
        int base_v;
        keys = 16'h0;
        do_reset();
        base_v = valid_total;
        keys = 16'h1 << 9;
        step(100);
        checks++; if (kp.key_down !== 1'b0) begin failures++; $display("FAIL single_early_down got=%b exp=0", kp.key_down); end
        step(25);
        checks++; if (kp.key_down !== 1'b1) begin failures++; $display("FAIL single_down got=%b exp=1", kp.key_down); end
        checks++; if (last_code !== 4'd9) begin failures++; $display("FAIL single_code got=%0d exp=9", last_code); end
        step(275);
        keys = 16'h0;
        step(110);
        checks++; if (kp.key_down !== 1'b1) begin failures++; $display("FAIL release_early got=%b exp=1", kp.key_down); end
        step(15);
        checks++; if (kp.key_down !== 1'b0) begin failures++; $display("FAIL release_down got=%b exp=0", kp.key_down); end
        checks++; if (kp.key_code !== 4'd9) begin failures++; $display("FAIL release_code got=%0d exp=9", kp.key_code); end
        checks++; if (valid_total - base_v != 1) begin failures++; $display("FAIL single_strobes got=%0d exp=1", valid_total - base_v); end
    endtask

    task automatic test_glitch();
        int base_v, base_r;
        keys = 16'h0;
        do_reset();
        base_v = valid_total; base_r = rise_total;
        keys = 16'h1 << 5;
        step(80);
        keys = 16'h0;
        step(320);
        checks++; if (valid_total - base_v != 0) begin failures++; $display("FAIL glitch_valid got=%0d exp=0", valid_total - base_v); end
        checks++; if (rise_total - base_r != 0) begin failures++; $display("FAIL glitch_down got=%0d exp=0", rise_total - base_r); end
    endtask

    task automatic test_multi_key();
        logic [15:0] masks [3];
        logic [3:0]  exp_code [3];
        int base_v;
        masks    = '{16'h4040, 16'h000A, 16'h9000};
        exp_code = '{4'd6, 4'd1, 4'd12};
        for (int i = 0; i < 3; i++) begin
            keys = 16'h0;
            do_reset();
            base_v = valid_total;
            keys = masks[i];
            step(130);
            checks++; if (kp.key_code !== exp_code[i]) begin failures++; $display("FAIL multi%0d_code got=%0d exp=%0d", i, kp.key_code, exp_code[i]); end
            checks++; if (valid_total - base_v != 1) begin failures++; $display("FAIL multi%0d_strobes got=%0d exp=1", i, valid_total - base_v); end
        end
        keys = 16'h0;
    endtask

    task automatic test_rollover();
        int base_v, base_f;
        keys = 16'h0;
        do_reset();
        base_v = valid_total; base_f = fall_total;
        keys = 16'h1 << 3;
        step(130);
        checks++; if (kp.key_code !== 4'd3) begin failures++; $display("FAIL roll_first got=%0d exp=3", kp.key_code); end
        step(30);
        keys = 16'h1 << 12;
        step(140);
        checks++; if (valid_total - base_v != 2) begin failures++; $display("FAIL roll_strobes got=%0d exp=2", valid_total - base_v); end
        checks++; if (kp.key_code !== 4'd12) begin failures++; $display("FAIL roll_code got=%0d exp=12", kp.key_code); end
        checks++; if (last_code !== 4'd12) begin failures++; $display("FAIL roll_strobe_code got=%0d exp=12", last_code); end
        checks++; if (fall_total - base_f != 0) begin failures++; $display("FAIL roll_down_drop got=%0d exp=0", fall_total - base_f); end
        keys = 16'h0;
    endtask

    task automatic test_reset_mid_scan();
        int base_v;
        keys = 16'h0;
        do_reset();
        keys = 16'h1 << 7;
        step(130);
        checks++; if (kp.key_code !== 4'd7) begin failures++; $display("FAIL mid_pre_code got=%0d exp=7", kp.key_code); end
        keys = 16'h0;
        step(230);
        keys = 16'h1 << 7;
        step(90);
        base_v = valid_total;
        rst = 1'b1;
        @(negedge clk_50M);
        checks++; if (kp.row !== 4'b1110) begin failures++; $display("FAIL mid_row got=%b exp=1110", kp.row); end
        checks++; if (kp.key_code !== 4'd0) begin failures++; $display("FAIL mid_code got=%0d exp=0", kp.key_code); end
        checks++; if (kp.key_down !== 1'b0 || kp.key_valid !== 1'b0) begin failures++; $display("FAIL mid_flags got=%b%b exp=00", kp.key_down, kp.key_valid); end
        rst = 1'b0;
        step(100);
        checks++; if (kp.key_down !== 1'b0) begin failures++; $display("FAIL mid_early got=%b exp=0", kp.key_down); end
        checks++; if (valid_total - base_v != 0) begin failures++; $display("FAIL mid_early_strobe got=%0d exp=0", valid_total - base_v); end
        step(25);
        checks++; if (kp.key_down !== 1'b1) begin failures++; $display("FAIL mid_accept got=%b exp=1", kp.key_down); end
        checks++; if (kp.key_code !== 4'd7) begin failures++; $display("FAIL mid_accept_code got=%0d exp=7", kp.key_code); end
        keys = 16'h0;
        step(200);
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_glitch();
        test_multi_key();
        test_rollover();
        test_reset_mid_scan();
        checks++;
        if (consec_total != 0) begin
            failures++; $display("FAIL strobe_consecutive got=%0d exp=0", consec_total);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
